// File: rtl/prio_encoder_arb_pkg.sv
// Shared constants and helpers for the registered priority encoder / arbiter.
package prio_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Widest request vector the helper accepts; callers zero-extend into it.
  localparam int MAX_N = 64;

  // True when two or more bits are set: clearing the lowest set bit leaves a residue.
  function automatic logic more_than_one(input logic [MAX_N-1:0] v);
    return (v & (v - MAX_N'(1))) != '0;
  endfunction

endpackage

// File: rtl/prio_encoder_arb_find_highest.sv
// Rotating highest-set search: the winner is the first set bit walking down from
// start-1 (wrapping mod N), with start itself lowest. start=0 gives plain highest-index.
module prio_find_highest #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  localparam int WP = W + 1;

  logic [N-1:0]  rot;
  logic [WP-1:0] hi;
  logic [WP-1:0] sum;

  // rot[k] = vec[(start + k) mod N]; highest k in rot is highest priority.
  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      logic [WP-1:0] j;
      j = {1'b0, start} + WP'(k);
      if (j >= WP'(N)) j = j - WP'(N);
      rot[k] = vec[j[W-1:0]];
    end
  end

  always_comb begin
    found = 1'b0;
    hi    = '0;
    for (int k = 0; k < N; k++) begin
      if (rot[k]) begin
        found = 1'b1;
        hi    = WP'(k);
      end
    end
    sum = {1'b0, start} + hi;
    if (sum >= WP'(N)) sum = sum - WP'(N);
    idx = sum[W-1:0];
  end

endmodule

// File: rtl/prio_encoder_arb.sv
// Registered N-input priority encoder / arbiter with masking, optional round-robin
// and a valid/ready output stage that holds its grant under backpressure.
module prio_encoder_arb
  import prio_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         rr_mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_multi
);

  logic [N-1:0] elig;
  logic         load;
  logic         accept;
  logic [W-1:0] last_grant;
  logic [W-1:0] ptr;
  logic [W-1:0] start;
  logic         found;
  logic [W-1:0] win_idx;

  assign elig   = req & ~mask;
  assign load   = !out_valid || out_ready;
  assign accept = out_valid && out_ready;

  // The grant being accepted this cycle already counts as the most recent one.
  assign ptr   = accept ? out_idx : last_grant;
  assign start = (rr_mode == MODE_FIXED) ? '0 : ptr;

  prio_find_highest #(.N(N)) u_find (
    .vec   (elig),
    .start (start),
    .found (found),
    .idx   (win_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_multi  <= 1'b0;
      last_grant <= '0;
    end else begin
      if (accept) last_grant <= out_idx;
      if (load) begin
        if (found) begin
          out_valid  <= 1'b1;
          out_idx    <= win_idx;
          out_onehot <= {{(N-1){1'b0}}, 1'b1} << win_idx;
          out_multi  <= more_than_one(MAX_N'(elig));
        end else begin
          // out_idx deliberately holds its last value when nothing is granted.
          out_valid  <= 1'b0;
          out_onehot <= '0;
          out_multi  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Bench for prio_encoder_arb: directed vectors with literal expectations plus a
// priority-list model compared against the outputs on every cycle after reset.
module tb_prio_encoder_arb;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         rr_mode;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         out_multi;

  int n_checks = 0;
  int n_fail   = 0;

  prio_encoder_arb #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .mask       (mask),
    .rr_mode    (rr_mode),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .out_multi  (out_multi)
  );

  always #5 clk = ~clk;

  // Model: walk the priority list p-1, p-2, ... p and take the first eligible requester.
  logic         m_valid;
  int           m_idx;
  logic [N-1:0] m_oh;
  logic         m_multi;
  int           m_last;
  logic         model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0; m_idx = 0; m_oh = '0; m_multi = 1'b0; m_last = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      logic [N-1:0] e;
      logic acc;
      int p, old_idx, win;
      e = req & ~mask;
      acc = m_valid && out_ready;
      old_idx = m_idx;
      if (!m_valid || out_ready) begin
        p = acc ? old_idx : m_last;
        if (!rr_mode) p = 0;
        if ($countones(e) == 0) begin
          m_valid = 1'b0; m_oh = '0; m_multi = 1'b0;
        end else begin
          win = -1;
          for (int d = 1; d <= N; d++) begin
            int c;
            c = (p - d + N) % N;
            if (win < 0 && e[c]) win = c;
          end
          m_valid = 1'b1;
          m_idx   = win;
          m_oh    = '0;
          m_oh[win] = 1'b1;
          m_multi = ($countones(e) > 1);
        end
      end
      if (acc) m_last = old_idx;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      n_checks++;
      if ({out_valid, out_idx, out_onehot, out_multi} !==
          {m_valid, W'(m_idx), m_oh, m_multi}) begin
        n_fail++;
        $display("FAIL model t=%0t got v=%b idx=%0d oh=%h multi=%b want v=%b idx=%0d oh=%h multi=%b",
                 $time, out_valid, out_idx, out_onehot, out_multi,
                 m_valid, m_idx, m_oh, m_multi);
      end
    end
  end

  task automatic drive(input logic r, input logic [N-1:0] rq, input logic [N-1:0] mk,
                       input logic rr, input logic rdy);
    rst = r; req = rq; mask = mk; rr_mode = rr; out_ready = rdy;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic v, input logic [W-1:0] i,
                     input logic [N-1:0] oh, input logic m);
    n_checks++;
    if ({out_valid, out_idx, out_onehot, out_multi} !== {v, i, oh, m}) begin
      n_fail++;
      $display("FAIL %s got v=%b idx=%0d oh=%h multi=%b want v=%b idx=%0d oh=%h multi=%b",
               nm, out_valid, out_idx, out_onehot, out_multi, v, i, oh, m);
    end
  endtask

  typedef struct {
    logic [N-1:0] rq;
    logic [N-1:0] mk;
    logic         rr;
    logic         rdy;
  } vec_t;

  vec_t tbl[12];
  int   rr_seq[9];

  initial begin
    drive(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);

    // Reset held for two cycles
    tick(); chk("reset0", 1'b0, 3'd0, 8'h00, 1'b0);
    tick(); chk("reset1", 1'b0, 3'd0, 8'h00, 1'b0);

    // Fixed priority, then idle
    drive(1'b0, 8'b0000_0101, 8'h00, 1'b0, 1'b1);
    tick(); chk("fixed_05", 1'b1, 3'd2, 8'h04, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tick(); chk("fixed_idle", 1'b0, 3'd2, 8'h00, 1'b0);

    // Backpressure: held grant survives a changed request
    drive(1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    tick(); chk("bp_load", 1'b1, 3'd4, 8'h10, 1'b0);
    drive(1'b0, 8'h80, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(); chk("bp_hold", 1'b1, 3'd4, 8'h10, 1'b0);
    end
    drive(1'b0, 8'h80, 8'h00, 1'b0, 1'b1);
    tick(); chk("bp_release", 1'b1, 3'd7, 8'h80, 1'b0);

    // Round-robin from reset, including wrap 0 -> 7
    rr_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    drive(1'b1, 8'hFF, 8'h00, 1'b1, 1'b1);
    tick(); chk("rr_reset", 1'b0, 3'd0, 8'h00, 1'b0);
    drive(1'b0, 8'hFF, 8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) begin
      logic [N-1:0] oh;
      oh = 8'h01 << rr_seq[k];
      tick(); chk("rr_seq", 1'b1, W'(rr_seq[k]), oh, 1'b1);
    end

    // Masking
    drive(1'b0, 8'hFF, 8'hF0, 1'b0, 1'b1);
    tick(); chk("mask_F0", 1'b1, 3'd3, 8'h08, 1'b1);
    drive(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1);
    tick(); chk("mask_FF", 1'b0, 3'd3, 8'h00, 1'b0);

    // Reset while a grant is stalled
    drive(1'b0, 8'h20, 8'h00, 1'b1, 1'b0);
    tick(); chk("mid_load", 1'b1, 3'd5, 8'h20, 1'b0);
    drive(1'b0, 8'hFF, 8'h00, 1'b1, 1'b0);
    tick(); chk("mid_hold", 1'b1, 3'd5, 8'h20, 1'b0);
    drive(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
    tick(); chk("mid_reset", 1'b0, 3'd0, 8'h00, 1'b0);
    drive(1'b0, 8'hFF, 8'h00, 1'b1, 1'b1);
    tick(); chk("mid_first", 1'b1, 3'd7, 8'h80, 1'b1);

    // Mixed vectors: sparse RR wrap, stalls, mode switches; checked by the model
    tbl = '{'{8'h81, 8'h00, 1'b1, 1'b1}, '{8'h81, 8'h00, 1'b1, 1'b1},
            '{8'h81, 8'h00, 1'b1, 1'b1}, '{8'h24, 8'h04, 1'b1, 1'b0},
            '{8'h24, 8'h00, 1'b1, 1'b0}, '{8'h24, 8'h00, 1'b1, 1'b1},
            '{8'h00, 8'h00, 1'b1, 1'b1}, '{8'h03, 8'h00, 1'b0, 1'b1},
            '{8'h03, 8'h02, 1'b0, 1'b1}, '{8'hAA, 8'h0F, 1'b1, 1'b1},
            '{8'hAA, 8'h00, 1'b1, 1'b1}, '{8'h01, 8'h00, 1'b1, 1'b0}};
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, tbl[k].rq, tbl[k].mk, tbl[k].rr, tbl[k].rdy);
      tick();
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
